// File: rtl/pixel_rescaler.sv
// pixel_rescaler: maps signed convolution results onto an NB_OUT-bit pixel range.
// The frame extremes are latched on i_start, then each accepted pixel is
// clamped, offset by the minimum, scaled by full scale and divided by the
// frame range with a restoring serial divider. Exactly one pixel is in flight.
module pixel_rescaler #(
  parameter int NB_PIXEL = 19,
  parameter int NB_COUNT = 32,
  parameter int NB_OUT   = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       i_start,
  input  logic signed [NB_PIXEL-1:0] i_maxValue,
  input  logic signed [NB_PIXEL-1:0] i_minValue,
  input  logic        [NB_COUNT-1:0] i_imageSize,
  input  logic                       i_valid,
  input  logic signed [NB_PIXEL-1:0] i_convValue,
  output logic                       o_ready,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic        [NB_OUT-1:0]   o_pixel,
  output logic                       o_done
);

  localparam int NB_RNG  = NB_PIXEL + 1;
  localparam int NB_NUM  = NB_PIXEL + 1 + NB_OUT;
  localparam int NB_REM  = NB_RNG + 1;
  localparam int NB_ITER = $clog2(NB_NUM + 1);

  localparam logic [NB_NUM-1:0]   FULL_SCALE = {{(NB_NUM-NB_OUT){1'b0}}, {NB_OUT{1'b1}}};
  localparam logic [NB_ITER-1:0]  ITER_LAST  = NB_ITER'(NB_NUM);
  localparam logic [NB_ITER-1:0]  ITER_ONE   = {{(NB_ITER-1){1'b0}}, 1'b1};
  localparam logic [NB_COUNT-1:0] CNT_ONE    = {{(NB_COUNT-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_READY = 3'd2,
    S_DIV   = 3'd3,
    S_OUT   = 3'd4
  } state_t;

  state_t                      state_q, state_d;
  logic signed [NB_PIXEL-1:0]  max_q, max_d;
  logic signed [NB_PIXEL-1:0]  min_q, min_d;
  logic        [NB_COUNT-1:0]  size_q, size_d;
  logic        [NB_COUNT-1:0]  count_q, count_d;
  logic        [NB_RNG-1:0]    range_q, range_d;
  logic        [NB_NUM-1:0]    work_q, work_d;
  logic        [NB_RNG-1:0]    rem_q, rem_d;
  logic        [NB_ITER-1:0]   iter_q, iter_d;
  logic        [NB_OUT-1:0]    pixel_q, pixel_d;
  logic                        ready_q, ready_d;
  logic                        valid_q, valid_d;
  logic                        done_q, done_d;

  logic signed [NB_PIXEL-1:0]  clamp_s;
  logic        [NB_RNG-1:0]    diff_s;
  logic        [NB_NUM-1:0]    num_s;
  logic        [NB_REM-1:0]    rem_shift_s;
  logic        [NB_REM-1:0]    rem_next_s;
  logic                        qbit_s;
  logic        [NB_NUM-1:0]    work_next_s;

  // Clamp the incoming pixel into [min,max] and form the scaled numerator.
  always_comb begin
    clamp_s = i_convValue;
    if (i_convValue < min_q) begin
      clamp_s = min_q;
    end else if (i_convValue > max_q) begin
      clamp_s = max_q;
    end else begin
      clamp_s = i_convValue;
    end
    // Sign-extend one bit so the difference never wraps; result is non-negative.
    diff_s = {clamp_s[NB_PIXEL-1], clamp_s} - {min_q[NB_PIXEL-1], min_q};
    num_s  = {{(NB_NUM-NB_RNG){1'b0}}, diff_s} * FULL_SCALE;
  end

  // One restoring-division step: shift in the next numerator bit, trial subtract.
  always_comb begin
    rem_shift_s = {rem_q, work_q[NB_NUM-1]};
    if (rem_shift_s >= {1'b0, range_q}) begin
      rem_next_s = rem_shift_s - {1'b0, range_q};
      qbit_s     = 1'b1;
    end else begin
      rem_next_s = rem_shift_s;
      qbit_s     = 1'b0;
    end
    work_next_s = {work_q[NB_NUM-2:0], qbit_s};
  end

  // Next-state and datapath control for the frame/pixel sequencer.
  always_comb begin
    state_d = state_q;
    max_d   = max_q;
    min_d   = min_q;
    size_d  = size_q;
    count_d = count_q;
    range_d = range_q;
    work_d  = work_q;
    rem_d   = rem_q;
    iter_d  = iter_q;
    pixel_d = pixel_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          max_d   = i_maxValue;
          min_d   = i_minValue;
          size_d  = i_imageSize;
          count_d = '0;
          if (i_imageSize == '0) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_LOAD;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        // An inverted range degenerates to zero, which forces all results to 0.
        if (max_q < min_q) begin
          range_d = '0;
        end else begin
          range_d = {max_q[NB_PIXEL-1], max_q} - {min_q[NB_PIXEL-1], min_q};
        end
        state_d = S_READY;
      end
      S_READY: begin
        if (i_valid) begin
          work_d  = num_s;
          rem_d   = '0;
          iter_d  = '0;
          state_d = S_DIV;
        end else begin
          state_d = S_READY;
        end
      end
      S_DIV: begin
        // NB_NUM shift steps, then one cycle to publish: fixed latency even for range 0.
        if (iter_q == ITER_LAST) begin
          if (range_q == '0) begin
            pixel_d = '0;
          end else begin
            pixel_d = work_q[NB_OUT-1:0];
          end
          state_d = S_OUT;
        end else begin
          work_d = work_next_s;
          rem_d  = NB_RNG'(rem_next_s);
          iter_d = iter_q + ITER_ONE;
        end
      end
      S_OUT: begin
        if (i_ready) begin
          count_d = count_q + CNT_ONE;
          if (count_d == size_q) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_READY;
          end
        end else begin
          state_d = S_OUT;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    ready_d = (state_d == S_READY);
    valid_d = (state_d == S_OUT);
  end

  // State and datapath registers; reset returns everything to idle immediately.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      max_q   <= '0;
      min_q   <= '0;
      size_q  <= '0;
      count_q <= '0;
      range_q <= '0;
      work_q  <= '0;
      rem_q   <= '0;
      iter_q  <= '0;
      pixel_q <= '0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      max_q   <= max_d;
      min_q   <= min_d;
      size_q  <= size_d;
      count_q <= count_d;
      range_q <= range_d;
      work_q  <= work_d;
      rem_q   <= rem_d;
      iter_q  <= iter_d;
      pixel_q <= pixel_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign o_ready = ready_q;
  assign o_valid = valid_q;
  assign o_pixel = pixel_q;
  assign o_done  = done_q;

endmodule

// File: tb/tb_pixel_rescaler.sv
// Self-checking bench for pixel_rescaler: directed scenarios plus randomized
// frames checked against an arithmetic reference of the rescale rule.
module tb_pixel_rescaler;

  localparam int NB_PIXEL = 19;
  localparam int NB_COUNT = 32;
  localparam int NB_OUT   = 8;
  localparam int LATENCY  = NB_PIXEL + 1 + NB_OUT + 1;

  logic                       clock;
  logic                       reset;
  logic                       i_start;
  logic signed [NB_PIXEL-1:0] i_maxValue;
  logic signed [NB_PIXEL-1:0] i_minValue;
  logic        [NB_COUNT-1:0] i_imageSize;
  logic                       i_valid;
  logic signed [NB_PIXEL-1:0] i_convValue;
  logic                       o_ready;
  logic                       o_valid;
  logic                       i_ready;
  logic        [NB_OUT-1:0]   o_pixel;
  logic                       o_done;

  int vectors = 0;
  int errors  = 0;

  pixel_rescaler #(.NB_PIXEL(NB_PIXEL), .NB_COUNT(NB_COUNT), .NB_OUT(NB_OUT)) dut (
    .clock(clock), .reset(reset), .i_start(i_start),
    .i_maxValue(i_maxValue), .i_minValue(i_minValue), .i_imageSize(i_imageSize),
    .i_valid(i_valid), .i_convValue(i_convValue), .o_ready(o_ready),
    .o_valid(o_valid), .i_ready(i_ready), .o_pixel(o_pixel), .o_done(o_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference: floor((clamp(x)-min)*(2^NB_OUT-1)/(max-min)), zero when max<=min.
  function automatic int ref_pixel(input longint x, input longint mn, input longint mx);
    longint c;
    if (mx <= mn) return 0;
    c = x;
    if (c < mn) c = mn;
    if (c > mx) c = mx;
    return int'(((c - mn) * ((64'sd1 <<< NB_OUT) - 64'sd1)) / (mx - mn));
  endfunction

  function automatic int rand_pix();
    return int'($urandom_range(0, (1 << NB_PIXEL) - 1)) - (1 << (NB_PIXEL - 1));
  endfunction

  task automatic start_frame(input int mx, input int mn, input int size);
    @(negedge clock);
    i_start     = 1'b1;
    i_maxValue  = NB_PIXEL'(mx);
    i_minValue  = NB_PIXEL'(mn);
    i_imageSize = NB_COUNT'(size);
    @(negedge clock);
    i_start = 1'b0;
  endtask

  // Drive one pixel through; returns observed latency (-1 on timeout), pixel and hold stability.
  task automatic xfer_pixel(input int x, input int hold, output int lat,
                            output logic [NB_OUT-1:0] pix, output bit stable_ok);
    int n;
    lat = -1; pix = '0; stable_ok = 1'b1;
    n = 0;
    while (!o_ready && n < 100) begin @(negedge clock); n++; end
    if (!o_ready) return;
    i_valid = 1'b1;
    i_convValue = NB_PIXEL'(x);
    @(posedge clock); #1;
    i_valid = 1'b0;
    n = 0;
    while (n < 200) begin
      @(posedge clock); #1; n++;
      if (o_valid) begin lat = n; break; end
    end
    if (lat < 0) return;
    pix = o_pixel;
    for (int i = 0; i < hold; i++) begin
      @(posedge clock); #1;
      if (!o_valid || o_pixel !== pix || o_ready) stable_ok = 1'b0;
    end
    i_ready = 1'b1;
    @(posedge clock); #1;
    i_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    vectors++;
    if ({o_ready, o_valid, o_pixel, o_done} !== '0) begin
      errors++; $display("FAIL reset_outputs: got %b required 0", {o_ready, o_valid, o_pixel, o_done});
    end
    reset = 1'b0;
    repeat (2) @(negedge clock);
    vectors++;
    if (o_ready !== 1'b0) begin errors++; $display("FAIL idle_ready: got %b required 0", o_ready); end
  endtask

  // Plays a whole frame, comparing every pixel, latency and the o_done pulse.
  task automatic play_frame(input string tag, input int mx, input int mn,
                            input int xs[$], input int hold);
    int lat; logic [NB_OUT-1:0] pix; bit st; int exp_p;
    start_frame(mx, mn, xs.size());
    foreach (xs[k]) begin
      exp_p = ref_pixel(xs[k], mn, mx);
      xfer_pixel(xs[k], hold, lat, pix, st);
      vectors++;
      if (lat != LATENCY) begin errors++; $display("FAIL %s_latency[%0d]: got %0d required %0d", tag, k, lat, LATENCY); end
      vectors++;
      if (pix !== NB_OUT'(exp_p)) begin errors++; $display("FAIL %s_pixel[%0d]: got %0d required %0d", tag, k, pix, exp_p); end
      if (hold > 0) begin
        vectors++;
        if (!st) begin errors++; $display("FAIL %s_hold[%0d]: output changed during backpressure", tag, k); end
      end
      vectors++;
      if (o_done !== (k == xs.size() - 1)) begin
        errors++; $display("FAIL %s_done[%0d]: got %b required %b", tag, k, o_done, k == xs.size() - 1);
      end
    end
    @(posedge clock); #1;
    vectors++;
    if (o_done !== 1'b0 || o_ready !== 1'b0) begin
      errors++; $display("FAIL %s_done_pulse: done %b ready %b required 0 0", tag, o_done, o_ready);
    end
  endtask

  task automatic test_basic();
    play_frame("basic", 99, 0, '{99, 50, 0}, 0);
  endtask

  task automatic test_clamp();
    play_frame("clamp", 99, 0, '{-1, 150}, 0);
  endtask

  task automatic test_zero_range();
    play_frame("zero_range", 5, 5, '{5, 7}, 0);
    play_frame("inverted", -3, 40, '{10}, 0);
  endtask

  task automatic test_backpressure();
    play_frame("backpressure", 1000, -1000, '{0}, 10);
  endtask

  task automatic test_empty_frame();
    start_frame(10, 0, 0);
    vectors++;
    if (o_done !== 1'b1) begin errors++; $display("FAIL empty_done: got %b required 1", o_done); end
    @(negedge clock);
    vectors++;
    if (o_done !== 1'b0 || o_ready !== 1'b0) begin
      errors++; $display("FAIL empty_idle: done %b ready %b required 0 0", o_done, o_ready);
    end
  endtask

  task automatic test_reset_mid();
    int n; bit quiet;
    start_frame(99, 0, 1);
    n = 0;
    while (!o_ready && n < 100) begin @(negedge clock); n++; end
    i_valid = 1'b1; i_convValue = NB_PIXEL'(40);
    @(posedge clock); #1;
    i_valid = 1'b0;
    repeat (10) @(posedge clock);
    #1 reset = 1'b1;
    #1;
    vectors++;
    if ({o_ready, o_valid, o_pixel, o_done} !== '0) begin
      errors++; $display("FAIL midreset_outputs: got %b required 0", {o_ready, o_valid, o_pixel, o_done});
    end
    @(negedge clock); reset = 1'b0;
    quiet = 1'b1;
    repeat (40) begin @(negedge clock); if (o_valid || o_done || o_ready) quiet = 1'b0; end
    vectors++;
    if (!quiet) begin errors++; $display("FAIL midreset_quiet: activity after reset, required none"); end
    play_frame("after_reset", 99, 0, '{99}, 0);
  endtask

  task automatic test_start_ignored();
    int lat; logic [NB_OUT-1:0] pix; bit st;
    start_frame(99, 0, 2);
    xfer_pixel(50, 0, lat, pix, st);
    vectors++;
    if (pix !== NB_OUT'(ref_pixel(50, 0, 99))) begin errors++; $display("FAIL ignore_first: got %0d required %0d", pix, ref_pixel(50, 0, 99)); end
    start_frame(10, -500, 1);
    vectors++;
    if (o_done !== 1'b0) begin errors++; $display("FAIL ignore_early_done: got %b required 0", o_done); end
    xfer_pixel(99, 0, lat, pix, st);
    vectors++;
    if (pix !== 8'd255) begin errors++; $display("FAIL ignore_pixel: got %0d required 255", pix); end
    vectors++;
    if (o_done !== 1'b1) begin errors++; $display("FAIL ignore_done: got %b required 1", o_done); end
  endtask

  task automatic test_random();
    int mx, mn, tmp, sz;
    int xs[$];
    for (int f = 0; f < 6; f++) begin
      mx = rand_pix(); mn = rand_pix();
      if (f != 5 && mx < mn) begin tmp = mx; mx = mn; mn = tmp; end
      if (f == 4) begin mn = mx - int'($urandom_range(1, 3)); end
      sz = int'($urandom_range(1, 5));
      xs.delete();
      for (int k = 0; k < sz; k++) begin
        if ($urandom_range(0, 3) == 0) xs.push_back(rand_pix());
        else if (mx > mn) xs.push_back(mn + int'($urandom_range(0, mx - mn)));
        else xs.push_back(rand_pix());
      end
      play_frame("random", mx, mn, xs, int'($urandom_range(0, 3)));
    end
  endtask

  initial begin
    reset = 1'b1; i_start = 1'b0; i_maxValue = '0; i_minValue = '0; i_imageSize = '0;
    i_valid = 1'b0; i_convValue = '0; i_ready = 1'b0;
    test_reset();
    test_basic();
    test_clamp();
    test_zero_range();
    test_backpressure();
    test_empty_frame();
    test_reset_mid();
    test_start_ignored();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
